regfile_wrport: RTL
===================

Name: regfile_wrport

Overview:
- 32x32 MIPS register file; the consumer of the regwr control produced by the decode LUTs.
- Commits write-back data on the clock edge when regwr is asserted, and serves two combinational read ports (rs, rt).
- $zero is hardwired to 0.
- Keeps a saturating count of committed writes and a last-written-address register for debug and bench observation.

Parameters:
- WIDTH, 32, data width of each register.
- DEPTH_LOG2, 5, address width; 2^DEPTH_LOG2 registers.
- CNT_WIDTH, 16, width of the committed-write counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- regwr  input  1  write enable, driven by the regwr decode.
- wraddr  input  DEPTH_LOG2  destination register (rd/rt/31, already muxed upstream).
- wrdata  input  WIDTH  write-back data.
- rdaddr1  input  DEPTH_LOG2  read port 1 address (rs).
- rdaddr2  input  DEPTH_LOG2  read port 2 address (rt).
- rddata1  output  WIDTH  read port 1 data.
- rddata2  output  WIDTH  read port 2 data.
- wr_count  output  CNT_WIDTH  number of committed writes since reset, saturating.
- last_wraddr  output  DEPTH_LOG2  address of the most recent committed write.
- last_wr_valid  output  1  high once any write has committed since reset.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset (reset_n=0, asynchronous, no clock needed) clears:
  - all registers to 0;
  - wr_count to 0;
  - last_wraddr to 0;
  - last_wr_valid to 0.
- Reset deasserts synchronously to clk at the system level; the first edge after release may commit a write.
- Commit rule: on a rising clk with reset_n=1, regwr=1 and wraddr!=0:
  - reg[wraddr] <= wrdata;
  - wr_count increments by 1;
  - last_wraddr <= wraddr;
  - last_wr_valid <= 1.
- Write to address 0 (regwr=1, wraddr=0):
  - register contents unchanged;
  - wr_count, last_wraddr and last_wr_valid unchanged;
  - the write counts as a dropped write.
- regwr=0: no state change; wraddr and wrdata are don't-care.
- Reads are combinational: rddataN = reg[rdaddrN], or 0 when rdaddrN=0, independent of regwr.
- Write-then-read latency: data written at edge N is visible on the read ports immediately after edge N. Same-cycle visibility depends on the optional feature.
- wr_count saturates at 2^CNT_WIDTH-1; further commits leave it unchanged.
- Both read ports may address the same register; both return identical data.
- Reset asserted mid-cycle with regwr=1: reset wins; no commit occurs.
- X on regwr is not required to be handled; the bench drives known values only.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: in the cycle where regwr=1, wraddr!=0 and rdaddrN==wraddr, rddataN = wrdata combinationally. This is write-first bypass for a single-cycle write-back/decode overlap. Address 0 still reads 0.
- Undefined: rddataN returns the stored (old) value until the edge commits. No bypass mux is present.

Test Plan:
1. Reset: hold reset_n=0 while clk runs, then release, with rdaddr1=5 and rdaddr2=31 -> rddata1=0, rddata2=0, wr_count=0, last_wr_valid=0. Assert reset_n=0 mid-cycle after prior writes -> all outputs 0 immediately, with no clock edge.
2. Basic write/read: regwr=1, wraddr=8, wrdata=32'hDEADBEEF for one edge; then regwr=0, rdaddr1=8 -> rddata1=32'hDEADBEEF, wr_count=1, last_wraddr=8, last_wr_valid=1.
3. $zero protection: regwr=1, wraddr=0, wrdata=32'hFFFFFFFF for one edge -> rddata1 at rdaddr1=0 is 0, wr_count unchanged, last_wraddr unchanged.
4. regwr gating: write 32'h1234 to reg 9, then apply regwr=0, wraddr=9, wrdata=32'h5678 for one edge -> reg 9 still reads 32'h1234, wr_count unchanged.
5. Bypass: reg 4 holds 32'hA; in the same cycle drive regwr=1, wraddr=4, wrdata=32'hB, rdaddr1=rdaddr2=4.
   - Before the edge, with REGFILE_WRITE_BYPASS_EN defined -> 32'hB on both ports.
   - Before the edge, without the macro -> 32'hA on both ports.
   - After the edge, either build -> 32'hB on both ports.
6. Counter saturation: build with CNT_WIDTH=4 and perform 20 commits to reg 1..20 -> wr_count=15 after the 15th commit and thereafter; last_wraddr=20.

Source files
------------

// File: rtl/regfile_wrport.sv
// 32x32 MIPS register file: one write port, two combinational read ports, $zero hardwired.
// Optional macro REGFILE_WRITE_BYPASS_EN enables write-first bypass onto the read ports.
module regfile_wrport #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  regwr,
  input  logic [DEPTH_LOG2-1:0] wraddr,
  input  logic [WIDTH-1:0]      wrdata,
  input  logic [DEPTH_LOG2-1:0] rdaddr1,
  input  logic [DEPTH_LOG2-1:0] rdaddr2,
  output logic [WIDTH-1:0]      rddata1,
  output logic [WIDTH-1:0]      rddata2,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output logic [DEPTH_LOG2-1:0] last_wraddr,
  output logic                  last_wr_valid
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Entry 0 has no storage; it always reads as zero.
  logic [WIDTH-1:0] regs [1:DEPTH-1];
  logic             commit;

  assign commit = regwr && (wraddr != '0);

  for (genvar g = 1; g < DEPTH; g++) begin : g_reg
    localparam logic [DEPTH_LOG2-1:0] ADDR = DEPTH_LOG2'(g);
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        regs[g] <= '0;
      end else if (commit && (wraddr == ADDR)) begin
        regs[g] <= wrdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_count      <= '0;
      last_wraddr   <= '0;
      last_wr_valid <= 1'b0;
    end else if (commit) begin
      if (wr_count != '1) begin
        wr_count <= wr_count + 1'b1;
      end
      last_wraddr   <= wraddr;
      last_wr_valid <= 1'b1;
    end
  end

  always_comb begin
    rddata1 = '0;
    if (rdaddr1 != '0) begin
      rddata1 = regs[rdaddr1];
`ifdef REGFILE_WRITE_BYPASS_EN
      if (commit && (rdaddr1 == wraddr)) begin
        rddata1 = wrdata;
      end
`endif
    end
  end

  always_comb begin
    rddata2 = '0;
    if (rdaddr2 != '0) begin
      rddata2 = regs[rdaddr2];
`ifdef REGFILE_WRITE_BYPASS_EN
      if (commit && (rdaddr2 == wraddr)) begin
        rddata2 = wrdata;
      end
`endif
    end
  end

endmodule
